// File: rtl/fp7_align_stage.sv
// Exponent-alignment stage for the 7-bit unsigned float (EW-bit exp, MW-bit mantissa, hidden 1).
// Define FP7_ALIGN_STICKY_EN to add the sticky output that ORs together the shifted-out bits.
module fp7_align_stage #(
    parameter int EW = 3,
    parameter int MW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EW+MW-1:0]  a,
    input  logic [EW+MW-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [EW-1:0]     exp_out,
    output logic [MW+1:0]     ma_out,
    output logic [MW+1:0]     mb_out,
`ifdef FP7_ALIGN_STICKY_EN
    output logic              sticky,
`endif
    output logic              swap
);

    localparam int CW = $clog2(MW + 3);
    localparam logic [EW:0] SAT = (EW + 1)'(MW + 2);

    // Handshake: a pair transfers on a rising edge where in_valid & in_ready are both high;
    // a result transfers on a rising edge where out_valid & out_ready are both high.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;

    logic [EW-1:0]   ea;
    logic [EW-1:0]   eb;
    logic            a_ge;
    logic [EW:0]     diff;
    logic [CW-1:0]   dsat;

    assign ea   = a[EW+MW-1:MW];
    assign eb   = b[EW+MW-1:MW];
    assign a_ge = (ea >= eb);
    // Widened by one bit so the subtraction can never wrap.
    assign diff = a_ge ? ({1'b0, ea} - {1'b0, eb}) : ({1'b0, eb} - {1'b0, ea});
    assign dsat = (diff >= SAT) ? CW'(MW + 2) : CW'(diff);

    assign in_ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            exp_out   <= '0;
            ma_out    <= '0;
            mb_out    <= '0;
            swap      <= 1'b0;
`ifdef FP7_ALIGN_STICKY_EN
            sticky    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        swap    <= ~a_ge;
                        exp_out <= a_ge ? ea : eb;
                        ma_out  <= {2'b01, (a_ge ? a[MW-1:0] : b[MW-1:0])};
                        mb_out  <= {2'b01, (a_ge ? b[MW-1:0] : a[MW-1:0])};
                        cnt     <= dsat;
`ifdef FP7_ALIGN_STICKY_EN
                        sticky  <= 1'b0;
`endif
                        if (dsat == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state     <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    mb_out <= mb_out >> 1;
                    cnt    <= cnt - CW'(1);
`ifdef FP7_ALIGN_STICKY_EN
                    sticky <= sticky | mb_out[0];
`endif
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
